// File: rtl/mc_control_fsm.sv
// Main control sequencer for the multi-cycle RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback and drives every datapath enable and select.
module mc_control_fsm #(
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_we,
    output logic                ir_we,
    output logic                adr_src,
    output logic                mem_we,
    output logic                reg_we,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          result_src,
    output logic [3:0]          state,
    output logic                illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

    state_t r_state;

    // Memory-handshake states stall in place; ILLEGAL is absorbing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:    r_state <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: r_state <= MEMADR;
                        OP_RTYPE:          r_state <= EXECR;
                        OP_ITYPE:          r_state <= EXECI;
                        OP_JAL:            r_state <= JAL;
                        OP_BRANCH:         r_state <= BEQ;
                        default:           r_state <= ILLEGAL;
                    endcase
                end
                MEMADR:   r_state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  r_state <= mem_ready ? MEMWB : MEMREAD;
                MEMWB:    r_state <= FETCH;
                MEMWRITE: r_state <= mem_ready ? FETCH : MEMWRITE;
                EXECR:    r_state <= ALUWB;
                EXECI:    r_state <= ALUWB;
                ALUWB:    r_state <= FETCH;
                JAL:      r_state <= ALUWB;
                BEQ:      r_state <= FETCH;
                ILLEGAL:  r_state <= ILLEGAL;
                default:  r_state <= FETCH;
            endcase
        end
    end

    logic w_pc_we;
    logic w_ir_we;
    logic w_mem_we;
    logic w_reg_we;
    logic w_illegal;

    always_comb begin
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_mem_we   = 1'b0;
        w_reg_we   = 1'b0;
        w_illegal  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        result_src = 2'b00;
        case (r_state)
            FETCH: begin
                w_pc_we    = mem_ready;
                w_ir_we    = mem_ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                w_reg_we   = 1'b1;
            end
            MEMWRITE: begin
                adr_src  = 1'b1;
                w_mem_we = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_FUNCT;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALU_FUNCT;
            end
            ALUWB:    w_reg_we = 1'b1;
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                w_pc_we   = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_SUB;
                w_pc_we   = zero;
            end
            ILLEGAL:  w_illegal = 1'b1;
            default: ;
        endcase
    end

    // FETCH enables follow mem_ready directly, so reset must mask them explicitly.
    assign pc_we   = w_pc_we  & ~rst;
    assign ir_we   = w_ir_we  & ~rst;
    assign mem_we  = w_mem_we & ~rst;
    assign reg_we  = w_reg_we & ~rst;
    assign illegal = w_illegal & ~rst;
    assign state   = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm: walks each instruction class and checks
// state sequence, enables and selects against hand-computed values.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_we;
    logic       ir_we;
    logic       adr_src;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [3:0] state;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    mc_control_fsm #(.ALU_OP_W(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src), .mem_we(mem_we),
        .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .state(state), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        opcode = 7'b0100011;
        mem_ready = 1'b1;
        zero = 1'b0;
        doReset();
        total++;
        if (state !== 4'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd5 || mem_we !== 1'b1) begin
            bad++; $display("[TB] FAIL reach_memwrite state=%0d mem_we=%b exp state=5 mem_we=1", state, mem_we);
        end
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || mem_we !== 1'b0 || pc_we !== 1'b0 || ir_we !== 1'b0 || reg_we !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid state=%0d mem_we=%b pc_we=%b ir_we=%b reg_we=%b ill=%b exp 0/all 0",
                     state, mem_we, pc_we, ir_we, reg_we, illegal);
        end
        total++;
        if (alu_src_b !== 2'b10 || result_src !== 2'b10 || adr_src !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_selects b=%b rs=%b adr=%b exp b=10 rs=10 adr=0", alu_src_b, result_src, adr_src);
        end
        rst = 1'b0;
        #1;
        total++;
        if (pc_we !== 1'b1 || ir_we !== 1'b1 || state !== 4'd0) begin
            bad++; $display("[TB] FAIL reset_release pc_we=%b ir_we=%b state=%0d exp 1 1 0", pc_we, ir_we, state);
        end
    endtask

    task automatic test_fetch_wait();
        doReset();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== 4'd0 || pc_we !== 1'b0 || ir_we !== 1'b0) begin
                bad++; $display("[TB] FAIL fetch_wait cyc=%0d state=%0d pc_we=%b ir_we=%b exp 0 0 0", i, state, pc_we, ir_we);
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        total++;
        if (state !== 4'd1) begin bad++; $display("[TB] FAIL fetch_exit state=%0d exp=1", state); end
    endtask

    task automatic test_lw();
        logic [3:0] exp [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        mem_ready = 1'b1;
        opcode = 7'b0000011;
        doReset();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (state !== exp[i] || reg_we !== (exp[i] == 4'd4)) begin
                bad++; $display("[TB] FAIL lw cyc=%0d state=%0d reg_we=%b exp state=%0d", i, state, reg_we, exp[i]);
            end
            if (exp[i] == 4'd4) begin
                total++;
                if (result_src !== 2'b01) begin bad++; $display("[TB] FAIL lw_result_src got=%b exp=01", result_src); end
            end
            if (exp[i] == 4'd3) begin
                total++;
                if (adr_src !== 1'b1 || result_src !== 2'b00) begin
                    bad++; $display("[TB] FAIL lw_memread adr=%b rs=%b exp 1 00", adr_src, result_src);
                end
            end
            tick();
        end
    endtask

    task automatic test_sw();
        int weCount = 0;
        mem_ready = 1'b1;
        opcode = 7'b0100011;
        doReset();
        tick(); tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== 4'd5 || mem_we !== 1'b1) begin
                bad++; $display("[TB] FAIL sw_hold cyc=%0d state=%0d mem_we=%b exp 5 1", i, state, mem_we);
            end
            if (mem_we === 1'b1) weCount++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (mem_we === 1'b1) weCount++;
        total++;
        if (weCount != 4) begin bad++; $display("[TB] FAIL sw_we_cycles got=%0d exp=4", weCount); end
        tick();
        total++;
        if (state !== 4'd0 || mem_we !== 1'b0) begin
            bad++; $display("[TB] FAIL sw_exit state=%0d mem_we=%b exp 0 0", state, mem_we);
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            mem_ready = 1'b1;
            opcode = 7'b1100011;
            zero = z[0];
            doReset();
            tick(); tick();
            total++;
            if (state !== 4'd10 || pc_we !== z[0] || alu_op !== 2'b01 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
                bad++;
                $display("[TB] FAIL beq_z%0d state=%0d pc_we=%b op=%b a=%b b=%b exp 10 %0d 01 10 00",
                         z, state, pc_we, alu_op, alu_src_a, alu_src_b, z);
            end
            tick();
            total++;
            if (state !== 4'd0) begin bad++; $display("[TB] FAIL beq_exit_z%0d state=%0d exp=0", z, state); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
        mem_ready = 1'b1;
        opcode = 7'b1101111;
        doReset();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (state !== exp[i] || pc_we !== (exp[i] == 4'd0 || exp[i] == 4'd9) || reg_we !== (exp[i] == 4'd7)) begin
                bad++;
                $display("[TB] FAIL jal cyc=%0d state=%0d pc_we=%b reg_we=%b exp state=%0d", i, state, pc_we, reg_we, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops  [2] = '{7'b0110011, 7'b0010011};
        logic [3:0] exec [2] = '{4'd6, 4'd8};
        logic [1:0] bsel [2] = '{2'b00, 2'b01};
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b1;
            opcode = ops[k];
            doReset();
            tick(); tick();
            total++;
            if (state !== exec[k] || alu_op !== 2'b10 || alu_src_a !== 2'b10 || alu_src_b !== bsel[k] || reg_we !== 1'b0) begin
                bad++;
                $display("[TB] FAIL exec_k%0d state=%0d op=%b a=%b b=%b reg_we=%b exp %0d 10 10 %b 0",
                         k, state, alu_op, alu_src_a, alu_src_b, reg_we, exec[k], bsel[k]);
            end
            tick();
            total++;
            if (state !== 4'd7 || reg_we !== 1'b1 || result_src !== 2'b00) begin
                bad++; $display("[TB] FAIL aluwb_k%0d state=%0d reg_we=%b rs=%b exp 7 1 00", k, state, reg_we, result_src);
            end
        end
    endtask

    task automatic test_illegal();
        mem_ready = 1'b1;
        opcode = 7'b1110011;
        doReset();
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (state !== 4'd11 || illegal !== 1'b1 || pc_we !== 1'b0 || ir_we !== 1'b0 || mem_we !== 1'b0 || reg_we !== 1'b0) begin
                bad++;
                $display("[TB] FAIL illegal cyc=%0d state=%0d ill=%b pc=%b ir=%b mw=%b rw=%b exp 11 1 0 0 0 0",
                         i, state, illegal, pc_we, ir_we, mem_we, reg_we);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            bad++; $display("[TB] FAIL illegal_reset state=%0d ill=%b exp 0 0", state, illegal);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        opcode = 7'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        #2;
        test_reset();
        test_fetch_wait();
        test_lw();
        test_sw();
        test_beq();
        test_jal();
        test_alu_ops();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
